// File: rtl/apb_timer_if.sv
// APB bus bundle between the requester and the timer completer.
interface apb_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer.sv
// APB timer: 32-bit prescaled up-counter with compare match, optional
// auto-reload or one-shot stop, and a level interrupt.
module apb_timer #(
    parameter int PS_W    = 16,
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    apb_timer_if.slave bus,
    output logic       irq
);
    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    // ctrl: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
    logic [2:0]      ctrl_q, ctrl_d;
    logic [PS_W-1:0] prescale_q, prescale_d;
    logic [31:0]     compare_q, compare_d;
    logic [31:0]     count_q, count_d;
    logic            match_q, match_d;
    logic [PS_W-1:0] pre_cnt_q, pre_cnt_d;
    logic            rd_wait_q, rd_wait_d;
    logic [31:0]     prdata_q, prdata_d;

    logic [2:0]      reg_sel;
    logic            rd_access;
    logic            rd_stall;
    logic            pready;
    logic            wr_en;
    logic            tick;
    logic            match_set;
    logic            match_clr;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign reg_sel   = bus.PADDR[4:2];
    assign rd_access = bus.PSEL & bus.PENABLE & ~bus.PWRITE;
    // First cycle of a read access stalls when a wait state is configured.
    assign rd_stall  = (RD_WAIT != 0) && rd_access && !rd_wait_q;
    // Reset forces a ready bus so an abandoned read never hangs the requester.
    assign pready    = !rd_stall || !rst;
    assign wr_en     = bus.PSEL & bus.PENABLE & bus.PWRITE & pready;
    assign tick      = ctrl_q[0] && (pre_cnt_q == prescale_q);

    assign bus.PREADY = pready;
    assign bus.PRDATA = ((RD_WAIT == 0) && rd_access) ? rdata : prdata_q;
    assign irq        = match_q & ctrl_q[2];

    assign unused_bits = &{1'b0, bus.PADDR[31:5], bus.PADDR[1:0], bus.PWDATA};

    // Register read multiplexer; unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_CTRL:     rdata[2:0]      = ctrl_q;
            A_PRESCALE: rdata[PS_W-1:0] = prescale_q;
            A_COMPARE:  rdata           = compare_q;
            A_COUNT:    rdata           = count_q;
            A_STATUS:   rdata[0]        = match_q;
            default:    rdata           = '0;
        endcase
    end

    // Next state: counting first, then APB writes so the bus wins conflicts.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        pre_cnt_d  = pre_cnt_q;
        rd_wait_d  = 1'b0;
        prdata_d   = prdata_q;
        match_set  = 1'b0;
        match_clr  = 1'b0;

        // Prescaler runs only while enabled and is parked at zero otherwise.
        if (ctrl_q[0]) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PS_W'(1);
        end else begin
            pre_cnt_d = '0;
        end

        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (reg_sel)
                A_CTRL: begin
                    ctrl_d = bus.PWDATA[2:0];
                    if (!bus.PWDATA[0]) begin
                        pre_cnt_d = '0;
                    end
                end
                A_PRESCALE: begin
                    prescale_d = bus.PWDATA[PS_W-1:0];
                    pre_cnt_d  = '0;
                end
                A_COMPARE: compare_d = bus.PWDATA;
                A_COUNT:   count_d   = bus.PWDATA;
                A_STATUS:  match_clr = bus.PWDATA[0];
                default:   ;
            endcase
        end

        // A new match overrides a simultaneous write-1-to-clear.
        match_d = (match_q & ~match_clr) | match_set;

        // Capture read data on the first access cycle; the wait flag lasts
        // exactly one cycle so each read takes SETUP + 2 cycles.
        if (rd_access) begin
            if (!rd_wait_q) begin
                prdata_d = rdata;
            end
            if (RD_WAIT != 0) begin
                rd_wait_d = ~rd_wait_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
            pre_cnt_q  <= '0;
            rd_wait_q  <= 1'b0;
            prdata_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            pre_cnt_q  <= pre_cnt_d;
            rd_wait_q  <= rd_wait_d;
            prdata_q   <= prdata_d;
        end
    end
endmodule

// File: tb/tb_apb_timer.sv
// Directed self-checking bench for apb_timer (PS_W=16, RD_WAIT=1).
module tb_apb_timer;
    logic        clk;
    logic        rst;
    logic        irq;
    int unsigned cyc;
    int          n_pass;
    int          n_total;

    apb_timer_if bus_if ();

    apb_timer #(.PS_W(16), .RD_WAIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(posedge clk); #1;
        bus_if.PSEL = 1'b1; bus_if.PENABLE = 1'b0; bus_if.PWRITE = 1'b1;
        bus_if.PADDR = addr; bus_if.PWDATA = data;
        @(posedge clk); #1;
        bus_if.PENABLE = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus_if.PREADY === 1'b1) break;
            n++;
            if (n > 20) begin
                $display("FAIL apb_write_timeout: PREADY=%b required 1", bus_if.PREADY);
                n_total++;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        bus_if.PSEL = 1'b0; bus_if.PENABLE = 1'b0;
        $display("apb wr addr=%08h data=%08h", addr, data);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
        @(posedge clk); #1;
        bus_if.PSEL = 1'b1; bus_if.PENABLE = 1'b0; bus_if.PWRITE = 1'b0;
        bus_if.PADDR = addr;
        @(posedge clk); #1;
        bus_if.PENABLE = 1'b1;
        waits = 0;
        data = '0;
        forever begin
            @(negedge clk);
            if (bus_if.PREADY === 1'b1) begin
                data = bus_if.PRDATA;
                break;
            end
            waits++;
            if (waits > 20) begin
                $display("FAIL apb_read_timeout: PREADY=%b required 1", bus_if.PREADY);
                n_total++;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        bus_if.PSEL = 1'b0; bus_if.PENABLE = 1'b0;
        $display("apb rd addr=%08h data=%08h waits=%0d", addr, data, waits);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int w;
        logic [31:0] addrs [5];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus_if.PREADY !== 1'b1) $display("FAIL reset_pready: got %b required 1", bus_if.PREADY);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b required 0", irq);
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apb_read(addrs[i], d, w);
            n_total++;
            if (d !== 32'h0) $display("FAIL reset_reg_%02h: got %08h required 00000000", addrs[i], d);
            else n_pass++;
        end
    endtask

    task automatic test_read_wait;
        logic [31:0] d;
        int w;
        apb_write(32'h08, 32'h1234);
        apb_read(32'h08, d, w);
        n_total++;
        if (w !== 1) $display("FAIL read_wait_cycles: got %0d required 1", w);
        else n_pass++;
        n_total++;
        if (d !== 32'h0000_1234) $display("FAIL read_compare: got %08h required 00001234", d);
        else n_pass++;
        apb_read(32'h28, d, w);
        n_total++;
        if (d !== 32'h0000_1234) $display("FAIL read_alias: got %08h required 00001234", d);
        else n_pass++;
        apb_write(32'h14, 32'hDEAD_BEEF);
        apb_read(32'h14, d, w);
        n_total++;
        if (d !== 32'h0) $display("FAIL read_unmapped: got %08h required 00000000", d);
        else n_pass++;
        apb_write(32'h00, 32'hFFFF_FFF8);
        apb_read(32'h00, d, w);
        n_total++;
        if (d !== 32'h0) $display("FAIL ctrl_raz: got %08h required 00000000", d);
        else n_pass++;
        apb_write(32'h04, 32'hABCD_1234);
        apb_read(32'h04, d, w);
        n_total++;
        if (d !== 32'h0000_1234) $display("FAIL prescale_width: got %08h required 00001234", d);
        else n_pass++;
    endtask

    task automatic test_one_shot;
        logic [31:0] d;
        int w;
        apb_write(32'h04, 32'd3);
        apb_write(32'h08, 32'd5);
        apb_write(32'h00, 32'h5);
        repeat (23) begin @(posedge clk); #1; end
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_early: got %b required 0", irq);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_24: got %b required 1", irq);
        else n_pass++;
        apb_read(32'h10, d, w);
        n_total++;
        if (d !== 32'h1) $display("FAIL oneshot_status: got %08h required 00000001", d);
        else n_pass++;
        apb_read(32'h00, d, w);
        n_total++;
        if (d !== 32'h4) $display("FAIL oneshot_ctrl: got %08h required 00000004", d);
        else n_pass++;
        repeat (10) @(posedge clk);
        apb_read(32'h0C, d, w);
        n_total++;
        if (d !== 32'd5) $display("FAIL oneshot_count: got %08h required 00000005", d);
        else n_pass++;
    endtask

    task automatic test_auto_reload;
        logic [31:0] d;
        logic [31:0] exp;
        int w;
        int unsigned e0;
        apb_write(32'h00, 32'h0);
        apb_write(32'h10, 32'h1);
        apb_write(32'h0C, 32'h0);
        apb_write(32'h08, 32'd2);
        apb_write(32'h04, 32'd0);
        apb_write(32'h00, 32'h7);
        e0 = cyc;
        repeat (2) begin @(posedge clk); #1; end
        n_total++;
        if (irq !== 1'b0) $display("FAIL reload_irq_early: got %b required 0", irq);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (irq !== 1'b1) $display("FAIL reload_irq_wrap: got %b required 1", irq);
        else n_pass++;
        // A read started r cycles after enable captures COUNT as of cycle r+2.
        for (int i = 0; i < 4; i++) begin
            exp = 32'((cyc - e0 + 2) % 3);
            apb_read(32'h0C, d, w);
            n_total++;
            if (d !== exp) $display("FAIL reload_count_%0d: got %08h required %08h", i, d, exp);
            else n_pass++;
        end
        while (((cyc - e0) % 3) != 0) begin @(posedge clk); #1; end
        apb_write(32'h10, 32'h1);
        n_total++;
        if (irq !== 1'b1) $display("FAIL w1c_on_match: got %b required 1", irq);
        else n_pass++;
        while (((cyc - e0) % 3) != 1) begin @(posedge clk); #1; end
        apb_write(32'h10, 32'h1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL w1c_clear: got %b required 0", irq);
        else n_pass++;
    endtask

    task automatic test_wrap_priority;
        logic [31:0] d;
        logic [31:0] exp;
        int w;
        int unsigned e0;
        apb_write(32'h00, 32'h0);
        apb_write(32'h10, 32'h1);
        apb_write(32'h04, 32'd0);
        apb_write(32'h08, 32'h10);
        apb_write(32'h0C, 32'hFFFF_FFFE);
        apb_write(32'h00, 32'h1);
        e0 = cyc;
        for (int i = 0; i < 2; i++) begin
            exp = 32'hFFFF_FFFE + 32'(cyc - e0 + 2);
            apb_read(32'h0C, d, w);
            n_total++;
            if (d !== exp) $display("FAIL wrap_count_%0d: got %08h required %08h", i, d, exp);
            else n_pass++;
        end
        apb_read(32'h10, d, w);
        n_total++;
        if (d !== 32'h0) $display("FAIL wrap_no_match: got %08h required 00000000", d);
        else n_pass++;
        apb_write(32'h0C, 32'd7);
        e0 = cyc;
        apb_read(32'h0C, d, w);
        n_total++;
        if (d !== 32'd9) $display("FAIL count_write_wins: got %08h required 00000009", d);
        else n_pass++;
        apb_write(32'h00, 32'h0);
        exp = 32'd7 + 32'(cyc - e0);
        repeat (5) @(posedge clk);
        apb_read(32'h0C, d, w);
        n_total++;
        if (d !== exp) $display("FAIL count_frozen: got %08h required %08h", d, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] d;
        int w;
        @(posedge clk); #1;
        bus_if.PSEL = 1'b1; bus_if.PENABLE = 1'b0; bus_if.PWRITE = 1'b0;
        bus_if.PADDR = 32'h08;
        @(posedge clk); #1;
        bus_if.PENABLE = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus_if.PREADY !== 1'b0) $display("FAIL midread_stall: got %b required 0", bus_if.PREADY);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (bus_if.PREADY !== 1'b1) $display("FAIL midread_pready: got %b required 1", bus_if.PREADY);
        else n_pass++;
        n_total++;
        if (bus_if.PRDATA !== 32'h0) $display("FAIL midread_prdata: got %08h required 00000000", bus_if.PRDATA);
        else n_pass++;
        $display("apb rd addr=00000008 abandoned by reset");
        bus_if.PSEL = 1'b0; bus_if.PENABLE = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        apb_read(32'h08, d, w);
        n_total++;
        if (d !== 32'h0) $display("FAIL midread_compare_reset: got %08h required 00000000", d);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst     = 1'b0;
        bus_if.PSEL    = 1'b0;
        bus_if.PENABLE = 1'b0;
        bus_if.PWRITE  = 1'b0;
        bus_if.PADDR   = '0;
        bus_if.PWDATA  = '0;
        test_reset;
        test_read_wait;
        test_one_shot;
        test_auto_reload;
        test_wrap_priority;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
